// File: rtl/address_router_pn.sv
// Address-decoding router with a one-deep registered output slice, outstanding-transaction
// tracking and same-target ordering. Optional decode-error routing: ADDRESS_ROUTER_DECERR_EN.
module address_router_pn #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int MAX_OUTST  = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'hF002_0000, 32'hF001_0000, 32'hF000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hE000_0000, 32'hE000_0000},
  localparam int SEL_W = $clog2(NUM_SLAVES + 1),
  localparam int CNT_W = $clog2(MAX_OUTST + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [LEN_W-1:0]            m_len,
  input  logic [2:0]                  m_size,
  input  logic [1:0]                  m_burst,
  input  logic                        m_valid,
  output logic                        m_ready,
  output logic [NUM_SLAVES*ADDR_W-1:0] s_addr,
  output logic [NUM_SLAVES*LEN_W-1:0] s_len,
  output logic [NUM_SLAVES*3-1:0]     s_size,
  output logic [NUM_SLAVES*2-1:0]     s_burst,
  output logic [NUM_SLAVES-1:0]       s_valid,
  input  logic [NUM_SLAVES-1:0]       s_ready,
  input  logic                        rsp_done,
  output logic [SEL_W-1:0]            sel_q,
  output logic [CNT_W-1:0]            outst_cnt,
  output logic                        dec_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic              out_valid;
  logic [SEL_W-1:0]  target_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;

  logic              dec_hit;
  logic [SEL_W-1:0]  dec_idx;
  logic [SEL_W-1:0]  dec_sel;
  logic              out_fire;
  logic              accept;
  logic              done_eff;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

`ifdef ADDRESS_ROUTER_DECERR_EN
  assign dec_sel = dec_hit ? dec_idx : SEL_W'(NUM_SLAVES);
`else
  assign dec_sel = dec_hit ? dec_idx : '0;
`endif

  always_comb begin
    s_valid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_valid[i] = out_valid && (target_q == SEL_W'(i));
    end
  end

  assign out_fire = |(s_valid & s_ready);
  assign m_ready  = reset && (!out_valid || out_fire) && (outst_cnt < MAX_CNT) &&
                    ((outst_cnt == '0) || (dec_sel == sel_q));
  assign accept   = m_valid && m_ready;
  assign done_eff = rsp_done && (outst_cnt != '0);

  assign s_addr  = {NUM_SLAVES{addr_q}};
  assign s_len   = {NUM_SLAVES{len_q}};
  assign s_size  = {NUM_SLAVES{size_q}};
  assign s_burst = {NUM_SLAVES{burst_q}};

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      target_q  <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      sel_q     <= '0;
      outst_cnt <= '0;
    end else begin
      if (accept) begin
        addr_q    <= m_addr;
        len_q     <= m_len;
        size_q    <= m_size;
        burst_q   <= m_burst;
        target_q  <= dec_sel;
        sel_q     <= dec_sel;
        out_valid <= (dec_sel < SEL_W'(NUM_SLAVES));
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      case ({accept, done_eff})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

`ifdef ADDRESS_ROUTER_DECERR_EN
  logic dec_err_q;
  always_ff @(posedge clk) begin
    if (!reset) dec_err_q <= 1'b0;
    else        dec_err_q <= accept && !dec_hit;
  end
  assign dec_err = dec_err_q;
`else
  assign dec_err = 1'b0;
`endif

endmodule
